// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package decoder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decode supported; callers narrow the result to their own N_OUT.
    localparam int MAX_OUT = 64;

    function automatic logic [MAX_OUT-1:0] onehot(input logic [31:0] idx);
        return {{(MAX_OUT-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Clearable up-counter with a terminal flag raised when the count equals the limit.
module hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/decoder_n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready accept, per-line hold and scan mode.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W  = 2,
    parameter  int HOLD_W = 4,
    localparam int N_OUT  = 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic [HOLD_W-1:0] hold,
    output logic [N_OUT-1:0]  dec_out,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

    state_e            state_q;
    logic [SEL_W-1:0]  idx_q;
    logic [HOLD_W-1:0] hold_q;
    logic              mode_q;
    logic [N_OUT-1:0]  dec_q;
    logic              done_q;

    logic [HOLD_W-1:0] cnt;
    logic              cnt_term;
    logic              cnt_clr;
    logic              cnt_inc;

    logic              accept;
    logic              abort;
    logic              finish;
    logic              advance;
    logic              last_line;
    logic [SEL_W-1:0]  line_idx_d;
    logic [N_OUT-1:0]  line_vec_d;

    hold_counter #(.W(HOLD_W)) u_hold_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .limit_i (hold_q),
        .cnt_o   (cnt),
        .term_o  (cnt_term)
    );

    always_comb begin
        accept     = (state_q == IDLE) && en && in_valid;
        last_line  = (mode_q == MODE_SINGLE) || (idx_q == LAST_IDX);
        abort      = (state_q == ACTIVE) && !en;
        finish     = (state_q == ACTIVE) && en && cnt_term && last_line;
        advance    = (state_q == ACTIVE) && en && cnt_term && !last_line;
        cnt_clr    = accept || abort || finish || advance;
        cnt_inc    = (state_q == ACTIVE) && en && !cnt_term;
        // idx_q + 1 only matters on advance, which never happens on the last line.
        line_idx_d = accept ? sel : idx_q + SEL_W'(1);
        line_vec_d = N_OUT'(onehot(32'(line_idx_d)));
    end

    // done is precomputed one edge early so it lines up with the final dec_out cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_SINGLE;
            dec_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ACTIVE;
                        idx_q   <= sel;
                        hold_q  <= hold;
                        mode_q  <= mode;
                        dec_q   <= line_vec_d;
                        done_q  <= (hold == '0) && ((mode == MODE_SINGLE) || (sel == LAST_IDX));
                    end
                end
                ACTIVE: begin
                    if (abort || finish) begin
                        state_q <= IDLE;
                        dec_q   <= '0;
                        done_q  <= 1'b0;
                    end else if (advance) begin
                        idx_q  <= line_idx_d;
                        dec_q  <= line_vec_d;
                        done_q <= (hold_q == '0) && (line_idx_d == LAST_IDX);
                    end else begin
                        done_q <= ((cnt + HOLD_W'(1)) == hold_q) && last_line;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dec_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && en;
    assign busy     = (state_q == ACTIVE);
    assign dec_out  = dec_q;
    assign done     = done_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed bench for decoder_n_seq: per-cycle scoreboard of {done, dec_out} while busy.
module tb_decoder_n_seq;

    localparam int SEL_W  = 2;
    localparam int HOLD_W = 4;
    localparam int N_OUT  = 2**SEL_W;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic [HOLD_W-1:0] hold;
    logic [N_OUT-1:0]  dec_out;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [N_OUT:0] exp_q[$];

    decoder_n_seq #(.SEL_W(SEL_W), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .mode     (mode),
        .hold     (hold),
        .dec_out  (dec_out),
        .busy     (busy),
        .done     (done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: every active cycle of a request, in order.
    task automatic push_expected(input logic [SEL_W-1:0] s, input logic m, input logic [HOLD_W-1:0] h);
        int line;
        logic last;
        logic [N_OUT-1:0] vec;
        line = int'(s);
        forever begin
            last = (m == 1'b0) || (line == N_OUT - 1);
            for (int c = 0; c <= int'(h); c++) begin
                vec = '0;
                vec[line] = 1'b1;
                exp_q.push_back({last && (c == int'(h)), vec});
            end
            if (last) break;
            line++;
        end
    endtask

    // Scoreboard: pop one expected entry per busy cycle; outputs must be quiet otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("active_out", 32'({done, dec_out}), 32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_out", 32'({done, dec_out}), 32'd0);
            end
        end
    end

    // Drivers: called #1 after a rising edge with the block IDLE and en high.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SEL_W-1:0] s, input logic m, input logic [HOLD_W-1:0] h, input bit push);
        in_valid = 1'b1;
        sel      = s;
        mode     = m;
        hold     = h;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        if (push) push_expected(s, m, h);
        tick();
        in_valid = 1'b0;
        sel      = SEL_W'($urandom_range(0, N_OUT - 1));
        mode     = 1'($urandom_range(0, 1));
        hold     = HOLD_W'($urandom_range(0, 2**HOLD_W - 1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(busy || (exp_q.size() != 0)), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        sel      = '0;
        mode     = 1'b0;
        hold     = '0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            en       = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            sel      = SEL_W'($urandom_range(0, N_OUT - 1));
            mode     = 1'($urandom_range(0, 1));
            hold     = HOLD_W'($urandom_range(0, 2**HOLD_W - 1));
            tick();
            check("reset_outs", 32'({busy, done, dec_out}), 32'd0);
        end
        en       = 1'b1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Single decode, latency and return to IDLE
        send(2'd2, 1'b0, 4'd0, 1'b1);
        check("single_c1_dec", 32'(dec_out), 32'h4);
        check("single_c1_done", 32'(done), 32'd1);
        tick();
        check("single_c2_dec", 32'(dec_out), 32'h0);
        check("single_c2_ready", 32'(in_ready), 32'd1);

        // 2-to-4 truth table sweep
        for (int s = 0; s < N_OUT; s++) begin
            send(SEL_W'(s), 1'b0, 4'd0, 1'b1);
            wait_idle(10);
        end

        // Hold: 4 cycles on line 1, then the maximum hold of 16 cycles
        send(2'd1, 1'b0, 4'd3, 1'b1);
        wait_idle(20);
        send(2'd3, 1'b0, 4'd15, 1'b1);
        wait_idle(40);

        // Scan sequences, including scan from the last line and a max-hold scan
        send(2'd1, 1'b1, 4'd1, 1'b1);
        wait_idle(20);
        check("scan_no_wrap", 32'(dec_out), 32'h0);
        send(2'd3, 1'b1, 4'd2, 1'b1);
        wait_idle(20);
        send(2'd2, 1'b1, 4'd15, 1'b1);
        wait_idle(60);
        send(2'd0, 1'b1, 4'd0, 1'b1);
        wait_idle(20);

        // Abort: en drops during the 4th active cycle
        send(2'd0, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 4'b0001});
        exp_q.push_back({1'b0, 4'b0010});
        tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        check("abort_dec", 32'(dec_out), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("abort_ready_low", 32'(in_ready), 32'd0);
            tick();
            check("abort_no_accept", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        en = 1'b1;
        #1;
        check("abort_ready_back", 32'(in_ready), 32'd1);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        sel      = 2'd3;
        mode     = 1'b0;
        hold     = 4'd0;
        push_expected(2'd3, 1'b0, 4'd0);
        tick();
        sel = 2'd0;
        push_expected(2'd0, 1'b0, 4'd0);
        check("b2b_first_dec", 32'(dec_out), 32'h8);
        check("b2b_first_ready", 32'(in_ready), 32'd0);
        tick();
        check("b2b_gap_dec", 32'(dec_out), 32'h0);
        check("b2b_gap_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_second_dec", 32'(dec_out), 32'h1);
        check("b2b_second_busy", 32'(busy), 32'd1);
        wait_idle(10);

        // Asynchronous reset in the middle of a long scan
        send(2'd0, 1'b1, 4'd15, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_dec", 32'(dec_out), 32'h0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        send(2'd1, 1'b0, 4'd1, 1'b1);
        wait_idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decoder_n_seq.md
Name: decoder_n_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. Generalises the 2-to-4 combinational decoder to SEL_W inputs and 2**SEL_W outputs.
- Adds a valid/ready request handshake, a programmable assert duration, and a scan mode that walks the one-hot output across consecutive lines.
- Drives chip-select or strobe lines for memory-mapped peripherals in the MIPS datapath.

Parameters:
- SEL_W, 2, select width; output width N_OUT = 2**SEL_W.
- HOLD_W, 4, width of the per-line hold count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low aborts any operation.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- sel  input  SEL_W  start line index.
- mode  input  1  0 = single decode, 1 = scan from sel to N_OUT-1.
- hold  input  HOLD_W  each line stays asserted hold+1 cycles.
- dec_out  output  N_OUT  registered one-hot (or all-zero) select lines.
- busy  output  1  high while in ACTIVE.
- done  output  1  one-cycle pulse on the final asserted cycle.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset, asserted at any time, including mid-operation:
  - FSM goes to IDLE.
  - dec_out=0, busy=0, done=0, internal counters=0.
  - in_ready reflects IDLE && en once rst_n deasserts.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - in_ready = en. dec_out=0.
  - Accept occurs on the clk edge where in_valid && in_ready.
  - On accept, the block captures sel into idx, hold into hold_r, and mode into mode_r, then moves to ACTIVE.
  - Input changes after the accept edge have no effect.
- ACTIVE:
  - dec_out = 1 << idx from the first cycle after the accept edge (latency 1).
  - in_ready=0 and busy=1.
  - cnt counts 0..hold_r. When cnt == hold_r:
    - If mode_r=0, or idx == N_OUT-1: last cycle. done=1 this cycle, and the next state is IDLE.
    - Else idx increments and cnt clears. The next line asserts in the immediately following cycle, with no gap and no overlap.
- done is registered-consistent: it is high exactly in the cycle where dec_out shows the last line.
- dec_out never has more than one bit set.
- Minimum gap between operations is one IDLE cycle, because in_ready is low during ACTIVE.
- Boundary conditions:
  - hold=0: each line is asserted for exactly 1 cycle.
  - hold=2**HOLD_W-1: each line is asserted for 2**HOLD_W cycles, with no counter overflow.
  - Scan with sel=N_OUT-1 behaves identically to mode 0.
  - Scan never wraps past N_OUT-1 to 0.
  - en low in ACTIVE (sampled at an edge): next cycle the FSM is in IDLE, dec_out=0, and done is NOT pulsed.
  - en low in IDLE: in_ready=0 and no accept.
  - in_valid held high across done: the first request is accepted on the IDLE cycle following done.

Decomposition:
- Shared package decoder_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - the MODE_SINGLE/MODE_SCAN constants;
  - a function onehot(idx) returning 1 << idx sized N_OUT.
- Optional sub-module: hold_counter, a loadable down/up counter with a terminal flag, sized HOLD_W.
- Everything else stays in decoder_n_seq.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then assert rst_n=0 asynchronously mid-ACTIVE.
  - dec_out=4'b0000, busy=0, done=0 immediately, without waiting for a clk edge.
- Single decode, SEL_W=2: accept sel=2, mode=0, hold=0.
  - Cycle +1: dec_out=4'b0100 and done=1.
  - Cycle +2: dec_out=0 and in_ready=1.
  - Sweep sel=0..3 and check outputs 0001/0010/0100/1000, matching the 2-to-4 truth table.
- Hold: accept sel=1, mode=0, hold=3.
  - dec_out=4'b0010 for exactly 4 cycles.
  - done high only in the 4th cycle.
- Scan: accept sel=1, mode=1, hold=1.
  - dec_out sequence 0010,0010,0100,0100,1000,1000, then 0000.
  - done high only in the 6th cycle.
  - No wrap to 0001.
- Abort: start scan sel=0, hold=2, then drive en=0 at the 4th active cycle.
  - Next cycle: dec_out=0, IDLE, done never pulses, in_ready stays 0 until en=1.
- Back-to-back: in_valid held high with two queued requests (sel=3 then sel=0, hold=0).
  - Second accept occurs exactly one IDLE cycle after the first done.
  - dec_out = 1000, 0000, 0001.
